// File: rtl/lvt_serial_host.sv
// Host-side serializer for the LVT memory test interface: one parallel command
// out as a bit frame plus push strobe, per-port read data back. Optional: LVT_SERIAL_HOST_STATS_EN.
module lvt_serial_host #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 512,
  parameter int PORTS     = 2,
  parameter int RET_DELAY = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [PORTS*$clog2(DEPTH)-1:0]    cmd_addr,
  input  logic [PORTS*WIDTH-1:0]            cmd_data,
  input  logic [PORTS-1:0]                  cmd_en,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [PORTS*WIDTH-1:0]            rsp_data,
  output logic                              ser_d,
  output logic                              ser_push,
  input  logic                              ser_q
`ifdef LVT_SERIAL_HOST_STATS_EN
  ,
  output logic [15:0]                       frame_count,
  output logic                              busy
`endif
);

  localparam int AW   = $clog2(DEPTH);
  localparam int N    = PORTS * (AW + WIDTH + 1);
  localparam int R    = PORTS * WIDTH;
  localparam int NR   = (N > R) ? N : R;
  // The wait counter shares the frame counter, so it must also hold RET_DELAY.
  localparam int CMAX = (NR > RET_DELAY) ? NR : RET_DELAY;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] SHIFT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CAP_LAST   = CW'(R - 1);
  localparam logic [CW-1:0] WAIT_LAST  = CW'((RET_DELAY > 1) ? (RET_DELAY - 2) : 0);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SHIFT   = 3'd1;
  localparam logic [2:0] S_PUSH    = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_CAPTURE = 3'd4;
  localparam logic [2:0] S_RESP    = 3'd5;

  logic [2:0]    state_reg;
  logic [CW-1:0] cnt_reg;
  logic [N-1:0]  shift_reg;
  logic [R-1:0]  ret_reg;
  logic [R-1:0]  rsp_data_reg;
  logic          cmd_ready_reg;
  logic          rsp_valid_reg;
  logic          ser_d_reg;
  logic          ser_push_reg;

  logic [N-1:0]  frame_word;
  logic [N-1:0]  frame_next;
  logic [N-1:0]  shift_next;
  logic [R-1:0]  ret_next;
  logic          accept;

  assign frame_word = {cmd_en, cmd_data, cmd_addr};
  // The MSB goes straight to ser_d at acceptance; the register keeps the remainder.
  assign frame_next = {frame_word[N-2:0], 1'b0};
  assign shift_next = {shift_reg[N-2:0], 1'b0};
  assign accept     = cmd_valid && cmd_ready_reg;

  generate
    if (R > 1) begin : g_ret_wide
      assign ret_next = {ret_reg[R-2:0], ser_q};
    end else begin : g_ret_bit
      assign ret_next = ser_q;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      shift_reg     <= '0;
      ret_reg       <= '0;
      rsp_data_reg  <= '0;
      cmd_ready_reg <= 1'b0;
      rsp_valid_reg <= 1'b0;
      ser_d_reg     <= 1'b0;
      ser_push_reg  <= 1'b0;
    end else begin
      ser_push_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          cmd_ready_reg <= !accept;
          if (accept) begin
            shift_reg <= frame_next;
            ser_d_reg <= frame_word[N-1];
            cnt_reg   <= '0;
            state_reg <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (cnt_reg == SHIFT_LAST) begin
            ser_d_reg    <= 1'b0;
            ser_push_reg <= 1'b1;
            cnt_reg      <= '0;
            state_reg    <= S_PUSH;
          end else begin
            ser_d_reg <= shift_reg[N-1];
            shift_reg <= shift_next;
            cnt_reg   <= cnt_reg + 1'b1;
          end
        end
        S_PUSH: begin
          cnt_reg   <= '0;
          state_reg <= (RET_DELAY > 1) ? S_WAIT : S_CAPTURE;
        end
        S_WAIT: begin
          if (cnt_reg == WAIT_LAST) begin
            cnt_reg   <= '0;
            state_reg <= S_CAPTURE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        S_CAPTURE: begin
          ret_reg <= ret_next;
          if (cnt_reg == CAP_LAST) begin
            rsp_data_reg  <= ret_next;
            rsp_valid_reg <= 1'b1;
            cnt_reg       <= '0;
            state_reg     <= S_RESP;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            cmd_ready_reg <= 1'b1;
            state_reg     <= S_IDLE;
          end
        end
        default: begin
          cmd_ready_reg <= 1'b0;
          rsp_valid_reg <= 1'b0;
          ser_d_reg     <= 1'b0;
          cnt_reg       <= '0;
          state_reg     <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign ser_d     = ser_d_reg;
  assign ser_push  = ser_push_reg;

`ifdef LVT_SERIAL_HOST_STATS_EN
  logic [15:0] frame_count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_count_reg <= '0;
    end else if (rsp_valid_reg && rsp_ready) begin
      frame_count_reg <= frame_count_reg + 16'd1;
    end
  end

  assign frame_count = frame_count_reg;
  assign busy        = (state_reg != S_IDLE);
`else
  // Statistics disabled: no counter and no extra ports.
`endif

endmodule

// File: tb/tb_lvt_serial_host.sv
// Scoreboard bench for lvt_serial_host: a far-end model answers each push,
// monitors check the serial frame and the parallel response independently.
module tb_lvt_serial_host;

  localparam int WIDTH     = 4;
  localparam int DEPTH     = 8;
  localparam int PORTS     = 2;
  localparam int RET_DELAY = 2;
  localparam int N         = 16;
  localparam int R         = 8;
  localparam int LAT       = N + 1 + RET_DELAY + R;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [5:0] cmd_addr = '0;
  logic [7:0] cmd_data = '0;
  logic [1:0] cmd_en = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_data;
  logic       ser_d;
  logic       ser_push;
  logic       ser_q = 1'b0;
`ifdef LVT_SERIAL_HOST_STATS_EN
  logic [15:0] frame_count;
  logic        busy;
`endif

  lvt_serial_host #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .PORTS(PORTS), .RET_DELAY(RET_DELAY)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_en(cmd_en),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .ser_d(ser_d), .ser_push(ser_push), .ser_q(ser_q)
`ifdef LVT_SERIAL_HOST_STATS_EN
    , .frame_count(frame_count), .busy(busy)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         acc;
    int         hold;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] frame_q[$];
  logic [7:0]  ret_q[$];

  int checks = 0;
  int errors = 0;
  int hs_cyc = -1;
  int push_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end else begin
      $display("ok   %s value=%0h (cycle %0d)", name, act, cyc);
    end
  endtask

  // Serial monitor: the N bits seen before each push must equal the expected frame.
  initial begin
    logic [15:0] hist;
    logic [15:0] ef;
    bit          push_prev;
    hist = '0;
    push_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hist = '0;
        push_prev = 1'b0;
      end else begin
        if (push_prev) chk("push_one_cycle", 32'(ser_push), 32'd0);
        if (ser_push) begin
          push_cnt++;
          chk("push_expected", 32'(frame_q.size() != 0), 32'd1);
          if (frame_q.size() != 0) begin
            ef = frame_q.pop_front();
            chk("ser_d_frame", 32'(hist), 32'(ef));
          end
          chk("ser_d_during_push", 32'(ser_d), 32'd0);
        end
        hist = {hist[14:0], ser_d};
        push_prev = ser_push;
      end
    end
  end

  // Far-end model: answers each push with the queued return word, MSB first.
  initial begin
    logic [7:0] rb;
    forever begin
      @(negedge clk);
      if (rst_n && ser_push && ret_q.size() != 0) begin
        rb = ret_q.pop_front();
        repeat (RET_DELAY) @(negedge clk);
        for (int i = R - 1; i >= 0; i--) begin
          ser_q = rb[i];
          @(negedge clk);
        end
        ser_q = 1'b0;
      end
    end
  end

  // Response monitor: pops the scoreboard on each new response and applies backpressure.
  initial begin
    exp_t       cur;
    bit         in_resp;
    bit         ready_chk;
    bit         bad;
    int         hold_left;
    logic [7:0] snap;
    in_resp = 1'b0;
    ready_chk = 1'b0;
    bad = 1'b0;
    hold_left = 0;
    snap = '0;
    cur = '{data: 8'h00, acc: 0, hold: 0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_resp = 1'b0;
        ready_chk = 1'b0;
        hold_left = 0;
        rsp_ready = 1'b1;
      end else begin
        if (ready_chk) begin
          chk("cmd_ready_after_rsp", 32'(cmd_ready), 32'd1);
          ready_chk = 1'b0;
        end
        if (rsp_valid && !in_resp) begin
          in_resp = 1'b1;
          bad = 1'b0;
          snap = rsp_data;
          chk("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            chk("rsp_data", 32'(rsp_data), 32'(cur.data));
            chk("rsp_latency", 32'(cyc - cur.acc), 32'(LAT));
          end else begin
            cur = '{data: 8'h00, acc: 0, hold: 0};
          end
          hold_left = cur.hold;
          if (hold_left > 0) rsp_ready = 1'b0;
        end else if (in_resp && hold_left > 0) begin
          if (!rsp_valid || rsp_data !== snap || cmd_ready) bad = 1'b1;
          hold_left--;
          if (hold_left == 0) rsp_ready = 1'b1;
        end
        if (in_resp && rsp_valid && rsp_ready) begin
          if (cur.hold > 0) chk("rsp_stable_backpressure", 32'(bad), 32'd0);
          chk("rsp_data_at_handshake", 32'(rsp_data), 32'(cur.data));
          hs_cyc = cyc;
          in_resp = 1'b0;
          ready_chk = 1'b1;
        end
      end
    end
  end

  task automatic send_cmd(input logic [1:0] en, input logic [7:0] data, input logic [5:0] addr,
                          input logic [15:0] frame, input logic [7:0] ret, input int hold,
                          input bit track, output int acc);
    int waited;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_en = en;
    cmd_data = data;
    cmd_addr = addr;
    waited = 0;
    while (!cmd_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) begin
      chk("cmd_accept", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc;
    if (track) begin
      exp_q.push_back('{data: ret, acc: cyc, hold: hold});
      frame_q.push_back(frame);
      ret_q.push_back(ret);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_en = ~en;
    cmd_data = ~data;
    cmd_addr = ~addr;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (!(cmd_ready && exp_q.size() == 0 && frame_q.size() == 0) && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    chk("drain_idle", 32'({cmd_ready, exp_q.size() == 0 && frame_q.size() == 0}), 32'd3);
  endtask

  initial begin
    int a;
    int a3;
    int a4;
    int pc;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data", 32'(rsp_data), 32'd0);
    chk("reset_ser_d", 32'(ser_d), 32'd0);
    chk("reset_ser_push", 32'(ser_push), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("cmd_ready_after_reset", 32'(cmd_ready), 32'd1);

    // Basic transaction from the worked example.
    send_cmd(2'b01, 8'hA5, 6'b101011, 16'h696B, 8'h3C, 0, 1'b1, a);
    drain();

    // Ten cycles of response backpressure.
    send_cmd(2'b10, 8'h3C, 6'b000111, 16'h8F07, 8'hC3, 10, 1'b1, a);
    drain();
`ifdef LVT_SERIAL_HOST_STATS_EN
    chk("frame_count_2", 32'(frame_count), 32'd2);
`endif

    // A second command offered mid-SHIFT waits for the first IDLE cycle.
    send_cmd(2'b11, 8'hFF, 6'b111000, 16'hFFF8, 8'h81, 0, 1'b1, a3);
    repeat (4) @(negedge clk);
`ifdef LVT_SERIAL_HOST_STATS_EN
    chk("busy_in_shift", 32'(busy), 32'd1);
`endif
    send_cmd(2'b00, 8'h5A, 6'b010101, 16'h1695, 8'h5E, 0, 1'b1, a4);
    chk("pending_accept_cycle", 32'(a4), 32'(hs_cyc + 1));
    drain();
`ifdef LVT_SERIAL_HOST_STATS_EN
    chk("frame_count_4", 32'(frame_count), 32'd4);
`endif

    // Reset pulled while shift bit 7 is on the line.
    send_cmd(2'b01, 8'hA5, 6'b101011, 16'h0000, 8'h00, 0, 1'b0, a);
    repeat (7) @(negedge clk);
    chk("abort_bit7_before_reset", 32'(ser_d), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_ser_d", 32'(ser_d), 32'd0);
    chk("abort_ser_push", 32'(ser_push), 32'd0);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_cmd_ready", 32'(cmd_ready), 32'd0);
`ifdef LVT_SERIAL_HOST_STATS_EN
    chk("abort_frame_count", 32'(frame_count), 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pc = push_cnt;
    repeat (60) @(negedge clk);
    chk("no_push_after_reset", 32'(push_cnt - pc), 32'd0);
    chk("idle_after_reset", 32'(cmd_ready), 32'd1);

    // Fresh command after the aborted one, short backpressure.
    send_cmd(2'b01, 8'h0F, 6'b110001, 16'h43F1, 8'h96, 2, 1'b1, a);
    drain();

`ifdef LVT_SERIAL_HOST_STATS_EN
    chk("frame_count_1", 32'(frame_count), 32'd1);
    force dut.frame_count_reg = 16'hFFFF;
    @(negedge clk);
    release dut.frame_count_reg;
    send_cmd(2'b01, 8'hA5, 6'b101011, 16'h696B, 8'h3C, 0, 1'b1, a);
    drain();
    chk("frame_count_wrap", 32'(frame_count), 32'd0);
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lvt_serial_host.md
Name: lvt_serial_host

Overview:
- Host-side driver for the serialized LVT memory test interface.
- Accepts one parallel LVT command: per-port address, write data and enable.
- Shifts the command out as a single-bit frame and pulses push.
- Waits a fixed return delay, deserializes the returned per-port read data from the single-bit return line, and presents it as a parallel response.
- Sits on the board/FPGA side opposite the LVT synthesis wrapper.

Parameters:
- WIDTH, 32, data bits per port
- DEPTH, 512, LVT entries; AW = $clog2(DEPTH)
- PORTS, 2, number of LVT ports
- RET_DELAY, 2, cycles from the push pulse to the first valid return bit on ser_q

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  host idle, can accept a command
- cmd_addr  in  PORTS*AW  port i address at [(i+1)*AW-1 -: AW]
- cmd_data  in  PORTS*WIDTH  port i write data at [(i+1)*WIDTH-1 -: WIDTH]
- cmd_en  in  PORTS  port i write enable at bit i
- rsp_valid  out  1  response held valid
- rsp_ready  in  1  response consumed
- rsp_data  out  PORTS*WIDTH  port i read data, same packing as cmd_data
- ser_d  out  1  serial command bit
- ser_push  out  1  one-cycle capture strobe to the far end
- ser_q  in  1  serial return bit

Behaviour:
- Frame length N = PORTS*(AW+WIDTH+1). Return length R = PORTS*WIDTH.
- Frame word F = {cmd_en, cmd_data, cmd_addr}, latched on acceptance. Transmitted MSB first: F[N-1] is the first bit on ser_d.
- Reset values: cmd_ready=0, rsp_valid=0, rsp_data=0, ser_d=0, ser_push=0, state=IDLE, counters=0. cmd_ready goes to 1 in the first cycle after reset release.
- Handshake rules: cmd accepted on the cycle with cmd_valid&&cmd_ready. Response retired on the cycle with rsp_valid&&rsp_ready. cmd_ready=1 only in IDLE.
- FSM:
  - IDLE: on accept, latch F into the shift register and go to SHIFT. cmd_ready drops the next cycle.
  - SHIFT: ser_d (registered) = current MSB; shift left once per cycle. Exactly N cycles, counted 0..N-1, then go to PUSH. ser_d holds F[N-1-k] in the k-th SHIFT cycle.
  - PUSH: ser_push=1 for exactly one cycle; ser_d=0. Go to WAIT.
  - WAIT: RET_DELAY-1 cycles, then go to CAPTURE. If RET_DELAY=1, go directly to CAPTURE.
  - CAPTURE: R cycles; sample ser_q each cycle into the LSB of the return shift register, shifting left. The first sampled bit ends at rsp_data[R-1]. Go to RESP.
  - RESP: rsp_valid=1; rsp_data stable. On rsp_ready, go to IDLE and drop rsp_valid. rsp_data holds its value until the next capture completes.
- Latency: accept to rsp_valid = N+1+RET_DELAY+R cycles, minimum, when rsp_ready=1.
- Back-to-back: cmd_ready returns the cycle after the response handshake. No command overlap; one command in flight at a time.
- cmd_* changes after acceptance: ignored (latched copy used).
- rsp_ready with rsp_valid=0: ignored.
- cmd_valid while busy: not accepted; the command stays pending until IDLE.
- Reset mid-operation: all state and outputs return to reset values immediately (asynchronous). The partial frame is discarded; no ser_push is issued.
- Counter widths: $clog2(max(N,R)+1) bits. Counters never wrap within a frame.

Optional Feature:
- Macro: LVT_SERIAL_HOST_STATS_EN.
- Defined:
  - Adds output frame_count[15:0], reset 0.
  - Increments by 1 on each rsp_valid&&rsp_ready handshake; wraps 0xFFFF->0x0000.
  - Adds output busy (state != IDLE).
- Undefined: neither port exists; no counter logic.

Test Plan:
- Config WIDTH=4, DEPTH=8, PORTS=2, RET_DELAY=2, so AW=3, N=16, R=8. Command cmd_en=2'b01, cmd_data=8'hA5, cmd_addr=6'b101_011. Required: ser_d over 16 cycles = 0,1,1,0,1,0,0,1,0,1,1,0,1,0,1,1. Then ser_push high for exactly 1 cycle.
- Return path: model drives ser_q = bits of 8'h3C MSB-first starting RET_DELAY cycles after push -> rsp_valid rises with rsp_data=8'h3C, 27 cycles after accept.
- Response backpressure: hold rsp_ready=0 for 10 cycles -> rsp_valid and rsp_data stay stable; cmd_ready stays 0. Raise rsp_ready -> cmd_ready=1 on the next cycle.
- Busy rejection: assert cmd_valid with new values during SHIFT -> not accepted; the in-flight ser_d sequence is unchanged. The new command is accepted in the first IDLE cycle.
- Reset mid-SHIFT: pull rst_n low at shift bit 7 -> ser_d=0, ser_push=0, rsp_valid=0 immediately. After release, no push occurs without a new command.
- With LVT_SERIAL_HOST_STATS_EN: 3 completed transactions -> frame_count=3. Preload to 0xFFFF, complete one -> frame_count=0.
